// File: rtl/rv32_pkg.sv
// Shared RV32IM definitions: decoded-op enum, opcode/funct constants,
// canonical NOP word, instruction format classes and encoder FSM states.
package rv32_pkg;

    typedef enum logic [5:0] {
        ALU_OP_NOP    = 6'd0,
        ALU_OP_ADD    = 6'd1,
        ALU_OP_SUB    = 6'd2,
        ALU_OP_SLL    = 6'd3,
        ALU_OP_SLT    = 6'd4,
        ALU_OP_SLTU   = 6'd5,
        ALU_OP_XOR    = 6'd6,
        ALU_OP_SRL    = 6'd7,
        ALU_OP_SRA    = 6'd8,
        ALU_OP_OR     = 6'd9,
        ALU_OP_AND    = 6'd10,
        ALU_OP_MUL    = 6'd11,
        ALU_OP_MULH   = 6'd12,
        ALU_OP_MULHSU = 6'd13,
        ALU_OP_MULHU  = 6'd14,
        ALU_OP_DIV    = 6'd15,
        ALU_OP_DIVU   = 6'd16,
        ALU_OP_REM    = 6'd17,
        ALU_OP_REMU   = 6'd18,
        ALU_OP_ADDI   = 6'd19,
        ALU_OP_SLTI   = 6'd20,
        ALU_OP_SLTIU  = 6'd21,
        ALU_OP_XORI   = 6'd22,
        ALU_OP_ORI    = 6'd23,
        ALU_OP_ANDI   = 6'd24,
        ALU_OP_SLLI   = 6'd25,
        ALU_OP_SRLI   = 6'd26,
        ALU_OP_SRAI   = 6'd27,
        ALU_OP_LB     = 6'd28,
        ALU_OP_LH     = 6'd29,
        ALU_OP_LW     = 6'd30,
        ALU_OP_LBU    = 6'd31,
        ALU_OP_LHU    = 6'd32,
        ALU_OP_SB     = 6'd33,
        ALU_OP_SH     = 6'd34,
        ALU_OP_SW     = 6'd35,
        ALU_OP_BEQ    = 6'd36,
        ALU_OP_BNE    = 6'd37,
        ALU_OP_BLT    = 6'd38,
        ALU_OP_BGE    = 6'd39,
        ALU_OP_BLTU   = 6'd40,
        ALU_OP_BGEU   = 6'd41,
        ALU_OP_JAL    = 6'd42,
        ALU_OP_JALR   = 6'd43,
        ALU_OP_LUI    = 6'd44,
        ALU_OP_AUIPC  = 6'd45
    } rv32_alu_op_t;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3: integer ALU (register and immediate forms)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    // funct3: M extension
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    // funct3: loads / stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    // funct3: branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    // addi x0, x0, 0
    localparam logic [31:0] RV32_NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_SH  = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6,
        FMT_BAD = 3'd7
    } rv32_instr_fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

    // True when v is a sign extension of its low (msb+1) bits.
    function automatic logic rv32_fits_signed(input logic [31:0] v, input int unsigned msb);
        logic all_zero;
        logic all_one;
        all_zero = 1'b1;
        all_one  = 1'b1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i >= msb) begin
                all_zero = all_zero & ~v[i];
                all_one  = all_one  &  v[i];
            end else begin
                all_zero = all_zero;
                all_one  = all_one;
            end
        end
        return all_zero | all_one;
    endfunction

endpackage

// File: rtl/rv32_encode_core.sv
// Combinational RV32IM encoder: maps one decoded packet to an instruction
// word plus an ok flag. Unencodable packets yield the canonical NOP.
module rv32_encode_core
    import rv32_pkg::*;
(
    input  rv32_alu_op_t alu_op,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    input  logic [4:0]   rd,
    input  logic [31:0]  imm,
    output logic [31:0]  word,
    output logic         ok
);

    rv32_instr_fmt_t fmt;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [31:0]     word_raw;
    logic            imm_ok;

    // Classify the operation and select opcode/funct fields.
    always_comb begin
        fmt = FMT_BAD;
        opc = 7'b0000000;
        f3  = 3'b000;
        f7  = F7_BASE;
        case (alu_op)
            ALU_OP_ADD:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_ADD;    end
            ALU_OP_SUB:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_ADD;    f7 = F7_ALT; end
            ALU_OP_SLL:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLL;    end
            ALU_OP_SLT:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLT;    end
            ALU_OP_SLTU:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLTU;   end
            ALU_OP_XOR:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_XOR;    end
            ALU_OP_SRL:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SR;     end
            ALU_OP_SRA:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SR;     f7 = F7_ALT; end
            ALU_OP_OR:     begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_OR;     end
            ALU_OP_AND:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_AND;    end
            ALU_OP_MUL:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_MUL;    f7 = F7_MULDIV; end
            ALU_OP_MULH:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_MULH;   f7 = F7_MULDIV; end
            ALU_OP_MULHSU: begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_MULHSU; f7 = F7_MULDIV; end
            ALU_OP_MULHU:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_MULHU;  f7 = F7_MULDIV; end
            ALU_OP_DIV:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_DIV;    f7 = F7_MULDIV; end
            ALU_OP_DIVU:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_DIVU;   f7 = F7_MULDIV; end
            ALU_OP_REM:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_REM;    f7 = F7_MULDIV; end
            ALU_OP_REMU:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_REMU;   f7 = F7_MULDIV; end
            ALU_OP_ADDI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_ADD;    end
            ALU_OP_SLTI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_SLT;    end
            ALU_OP_SLTIU:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_SLTU;   end
            ALU_OP_XORI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_XOR;    end
            ALU_OP_ORI:    begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_OR;     end
            ALU_OP_ANDI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_AND;    end
            ALU_OP_SLLI:   begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SLL;    end
            ALU_OP_SRLI:   begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR;     end
            ALU_OP_SRAI:   begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR;     f7 = F7_ALT; end
            ALU_OP_LB:     begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_B;      end
            ALU_OP_LH:     begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_H;      end
            ALU_OP_LW:     begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_W;      end
            ALU_OP_LBU:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_BU;     end
            ALU_OP_LHU:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_HU;     end
            ALU_OP_SB:     begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_B;      end
            ALU_OP_SH:     begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_H;      end
            ALU_OP_SW:     begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_W;      end
            ALU_OP_BEQ:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BEQ;    end
            ALU_OP_BNE:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BNE;    end
            ALU_OP_BLT:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLT;    end
            ALU_OP_BGE:    begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BGE;    end
            ALU_OP_BLTU:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLTU;   end
            ALU_OP_BGEU:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BGEU;   end
            ALU_OP_JAL:    begin fmt = FMT_J;  opc = OPC_JAL;    end
            ALU_OP_JALR:   begin fmt = FMT_I;  opc = OPC_JALR;   f3 = 3'b000;    end
            ALU_OP_LUI:    begin fmt = FMT_U;  opc = OPC_LUI;    end
            ALU_OP_AUIPC:  begin fmt = FMT_U;  opc = OPC_AUIPC;  end
            default:       begin fmt = FMT_BAD; end
        endcase
    end

    // Pack fields per format and check the immediate fits its encoding.
    always_comb begin
        word_raw = RV32_NOP_WORD;
        imm_ok   = 1'b0;
        case (fmt)
            FMT_R: begin
                word_raw = {f7, rs2, rs1, f3, rd, opc};
                imm_ok   = 1'b1;
            end
            FMT_I: begin
                word_raw = {imm[11:0], rs1, f3, rd, opc};
                imm_ok   = rv32_fits_signed(imm, 11);
            end
            FMT_SH: begin
                word_raw = {f7, imm[4:0], rs1, f3, rd, opc};
                imm_ok   = (imm[31:5] == 27'd0);
            end
            FMT_S: begin
                word_raw = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
                imm_ok   = rv32_fits_signed(imm, 11);
            end
            FMT_B: begin
                word_raw = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                imm_ok   = ~imm[0] & rv32_fits_signed(imm, 12);
            end
            FMT_J: begin
                word_raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                imm_ok   = ~imm[0] & rv32_fits_signed(imm, 20);
            end
            FMT_U: begin
                word_raw = {imm[31:12], rd, opc};
                imm_ok   = (imm[11:0] == 12'd0);
            end
            default: begin
                word_raw = RV32_NOP_WORD;
                imm_ok   = 1'b0;
            end
        endcase
    end

    // Substitute the canonical NOP whenever the packet cannot be encoded.
    always_comb begin
        ok = imm_ok;
        if (imm_ok) begin
            word = word_raw;
        end else begin
            word = RV32_NOP_WORD;
        end
    end

endmodule

// File: rtl/rv32_instr_encoder.sv
// Streaming program loader: accepts decoded packets over valid/ready,
// encodes each and writes it to consecutive instruction-memory words.
module rv32_instr_encoder
    import rv32_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  length,
    input  logic              in_valid,
    output logic              in_ready,
    input  rv32_alu_op_t      in_alu_op,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm32,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_count
);

    enc_state_t        state;
    enc_state_t        next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  remain_q;
    logic [31:0]       enc_word;
    logic              enc_ok;
    logic              handshake;
    logic              load;

    rv32_encode_core u_core (
        .alu_op (in_alu_op),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .rd     (in_rd),
        .imm    (in_imm32),
        .word   (enc_word),
        .ok     (enc_ok)
    );

    // in_ready is only ever high in RUN with packets outstanding.
    assign handshake = in_valid & in_ready;
    assign load      = (state == ST_IDLE) & start;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; RUN leaves once every packet has been written.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (length == {CNT_W{1'b0}}) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_RUN;
                    end
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (remain_q == {CNT_W{1'b0}}) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_RUN;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Load bookkeeping: address/length capture, write strobe and error tally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= {ADDR_W{1'b0}};
            remain_q   <= {CNT_W{1'b0}};
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= {ADDR_W{1'b0}};
            imem_wdata <= 32'h0000_0000;
            err        <= 1'b0;
            err_count  <= {CNT_W{1'b0}};
        end else begin
            imem_we <= handshake;
            if (load) begin
                addr_q    <= base_addr;
                remain_q  <= length;
                in_ready  <= (length != {CNT_W{1'b0}});
                err       <= 1'b0;
                err_count <= {CNT_W{1'b0}};
            end else if (handshake) begin
                imem_addr  <= addr_q;
                imem_wdata <= enc_word;
                addr_q     <= addr_q + ADDR_W'(1);
                remain_q   <= remain_q - CNT_W'(1);
                in_ready   <= (remain_q != CNT_W'(1));
                if (!enc_ok) begin
                    err <= 1'b1;
                    if (err_count != {CNT_W{1'b1}}) begin
                        err_count <= err_count + CNT_W'(1);
                    end else begin
                        err_count <= err_count;
                    end
                end else begin
                    err <= err;
                end
            end else begin
                in_ready <= in_ready & (state == ST_RUN);
            end
        end
    end

    // Status flags: busy tracks RUN, done pulses on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (next_state == ST_RUN);
            done <= (next_state == ST_DONE) & (state != ST_DONE);
        end
    end

endmodule

// File: doc/rv32_instr_encoder.md
# rv32_instr_encoder

Streaming RV32IM instruction encoder and program loader: the inverse of the operand-fetch decode stage. Accepts decoded instruction packets (alu_op, rs1/rs2/rd selects, imm32) over a valid/ready handshake, encodes each into a 32-bit RV32 instruction word and writes it to instruction memory at consecutive word addresses. Used by test harnesses and the boot path to build programs from packet streams. Reports unencodable packets through a sticky error flag.

## Interface

Parameters:
- ADDR_W, 10: instruction-memory word-address width.
- CNT_W, 10: width of the program-length counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address, captured on start.
- length  in  CNT_W  number of packets to load, captured on start; 0 means go directly to DONE.
- in_valid  in  1  packet valid.
- in_ready  out  1  encoder can accept a packet.
- in_alu_op  in  rv32_alu_op_t  operation to encode.
- in_rs1, in_rs2, in_rd  in  5 each  register selects.
- in_imm32  in  32  immediate in the same form produced by the decode stage.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on entry to DONE.
- err  out  1  sticky; set on any unencodable packet, cleared by start or reset.
- err_count  out  CNT_W  number of rejected packets in the current load; saturates.

## Operation

- FSM: IDLE, RUN, DONE.
- IDLE to RUN on start when length is not 0. Captures base_addr into addr_q and length into remain_q. Clears err and err_count. IDLE to DONE on start when length is 0.
- RUN: in_ready = 1 while remain_q > 0. A handshake is in_valid && in_ready. Each handshake decrements remain_q.
- RUN to DONE on the cycle the final write strobe is issued.
- DONE: pulse done for one cycle, then return to IDLE.
- Encoding, by alu_op:
  - R-type (ADD..AND, MUL..REMU): rd/rs1/rs2 with funct7 0x00, 0x20 (SUB, SRA) or 0x01 (M-extension).
  - I-type (ADDI..ANDI, loads, JALR): imm32 must lie in [-2048, 2047].
  - SLLI/SRLI/SRAI: imm32[4:0] is the shamt; imm32[31:5] must be 0. SRAI sets funct7 = 0x20.
  - S-type stores: imm32 must lie in [-2048, 2047].
  - B-type: imm32 must be even and lie in [-4096, 4094].
  - J (JAL): imm32 must be even and lie in [-2^20, 2^20-2].
  - U (LUI, AUIPC): imm32[11:0] must be 0.
- Unencodable packet (ALU_OP_NOP, unknown op, or immediate out of range or misaligned):
  - writes the canonical NOP 0x00000013 at the slot;
  - sets err and increments err_count;
  - the address still advances.
- Fields irrelevant to a format are ignored (e.g. rs2 for I-type).

## Timing

- Reset values: state IDLE; in_ready, imem_we, busy, done and err = 0; imem_addr, imem_wdata and err_count = 0.
- Latency: a handshake at edge N produces imem_we = 1 with the registered addr and wdata during cycle N+1. Throughput is one word per cycle. There is no memory backpressure.
- Address: addr_q increments by 1 after each write and wraps modulo 2^ADDR_W without an error.
- The last handshake deasserts in_ready in the following cycle. done is asserted in the cycle after the last write strobe.
- start during RUN or DONE is ignored.
- Async reset mid-load aborts immediately: no further strobes, no done pulse, and err is cleared.
- in_valid while in_ready = 0 has no effect; the packet is not consumed.

## Structure

- Shared rv32_pkg holds:
  - rv32_alu_op_t, opcode, funct3 and funct7 constants (already present);
  - a new RV32_NOP_WORD = 32'h0000_0013;
  - a new rv32_instr_fmt_t enum: R, I, SH, S, B, U, J, BAD.
- Sub-module rv32_encode_core: purely combinational. Maps packet fields to {word[31:0], ok}. The top holds the FSM, counters and output registers.

## Test plan

- length 1, base 0x010: ADD x3,x1,x2 -> imem_we for one cycle, addr 0x010, wdata 0x002081B3; done one cycle later.
- length 4, base 0: ADDI x1,x0,5; SUB x3,x1,x2; BEQ x1,x2,+8; LUI x5,0x12345000 -> wdata 0x00500093, 0x402081B3, 0x00208463, 0x123452B7 at addresses 0..3 on back-to-back cycles; err = 0.
- BEQ with imm32 = 3, then ADDI imm32 = 4096 -> both slots get 0x00000013; err = 1; err_count = 2.
- Wrap: ADDR_W = 10, base 0x3FF, length 2 -> writes at 0x3FF, then 0x000.
- Gapped in_valid plus a start pulse mid-RUN -> the start is ignored; addresses stay contiguous; the in_ready low cycle after the last handshake drops the extra packet.
- rst asserted after the 2nd of 4 writes -> outputs at reset values in the same cycle; no done pulse; a fresh start restarts cleanly.
